// File: rtl/vga_pixel_prefetch_if.sv
// Pixel/framebuffer bus between the prefetcher (master) and its
// surroundings: timing generator requests and framebuffer read port.
interface vga_pixel_prefetch_if #(
   parameter int ADDR_W = 19
);
   logic              frame_start;
   logic              pix_req;
   logic [3:0]        pix_r;
   logic [3:0]        pix_g;
   logic [3:0]        pix_b;
   logic              pix_valid;
   logic              fb_rd_en;
   logic [ADDR_W-1:0] fb_rd_addr;
   logic [11:0]       fb_rd_data;
   logic              underflow;

   modport master (
      input  frame_start, pix_req, fb_rd_data,
      output pix_r, pix_g, pix_b, pix_valid, fb_rd_en, fb_rd_addr, underflow
   );

   modport slave (
      output frame_start, pix_req, fb_rd_data,
      input  pix_r, pix_g, pix_b, pix_valid, fb_rd_en, fb_rd_addr, underflow
   );
endinterface

// File: rtl/vga_pixel_prefetch.sv
// Framebuffer read-ahead for the VGA timing generator: credit-limited reads
// fill a small pixel FIFO that is popped once per pixel request.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset; no reads until the first frame start
// S_FETCH | issuing reads whenever FIFO + in-flight leaves a free slot
// S_DONE  | last address of the frame issued; FIFO drains, no reads
module vga_pixel_prefetch #(
   parameter int H_VISIBLE_AREA = 800,
   parameter int V_VISIBLE_AREA = 600,
   parameter int FIFO_DEPTH     = 16,
   parameter int RD_LATENCY     = 2,
   parameter int ADDR_W         = 19
) (
   input  logic                 vga_clk_i,
   input  logic                 reset_i,
   vga_pixel_prefetch_if.master bus
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int PIXELS = H_VISIBLE_AREA * V_VISIBLE_AREA;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
   localparam logic [CNT_W:0]    CREDITS   = (CNT_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                state_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [RD_LATENCY-1:0] inflight_q;
   logic [RD_LATENCY-1:0] inflight_d;
   logic [11:0]           mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [CNT_W-1:0]      count_q;
   logic [CNT_W-1:0]      count_d;
   logic [11:0]           pix_rgb_q;
   logic                  pix_valid_q;
   logic                  underflow_q;

   logic                  frame_start;
   logic                  pix_req;
   logic [CNT_W-1:0]      inflight_cnt;
   logic [CNT_W:0]        credit_used;
   logic                  credit_ok;
   logic                  rd_en;
   logic                  fifo_wr;
   logic                  fifo_pop;
   logic                  fifo_empty;

   assign frame_start = bus.frame_start;
   assign pix_req     = bus.pix_req;
   assign fifo_empty  = (count_q == '0);

   // Reads already issued but not yet returned still own a FIFO slot.
   always_comb begin
      inflight_cnt = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight_cnt = inflight_cnt + CNT_W'(inflight_q[i]);
      end
   end

   assign credit_used = {1'b0, count_q} + {1'b0, inflight_cnt};
   assign credit_ok   = (credit_used < CREDITS);

   // A frame start cycle never reads, never writes and never pops.
   always_comb begin
      rd_en      = (state_q == S_FETCH) && credit_ok && !frame_start && !reset_i;
      fifo_wr    = inflight_q[RD_LATENCY-1] && !frame_start;
      fifo_pop   = pix_req && !fifo_empty && !frame_start;
      inflight_d = (inflight_q << 1) | RD_LATENCY'(rd_en);
      count_d    = count_q + CNT_W'(fifo_wr) - CNT_W'(fifo_pop);
   end

   always_ff @(posedge vga_clk_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         inflight_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         pix_rgb_q   <= '0;
         pix_valid_q <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         pix_valid_q <= fifo_pop;
         pix_rgb_q   <= fifo_pop ? mem_q[rd_ptr_q] : 12'h000;

         if (frame_start) begin
            // Returns from reads of the old frame are dropped by clearing
            // the in-flight tracker along with the FIFO.
            state_q     <= S_FETCH;
            addr_q      <= '0;
            inflight_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
         end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;

            if (fifo_wr) begin
               mem_q[wr_ptr_q] <= bus.fb_rd_data;
               wr_ptr_q        <= wr_ptr_q + 1'b1;
            end

            if (fifo_pop) begin
               rd_ptr_q <= rd_ptr_q + 1'b1;
            end

            // No bypass: a request against an empty FIFO is an underflow even
            // if a pixel is being written in the same cycle.
            if (pix_req && fifo_empty) begin
               underflow_q <= 1'b1;
            end

            case (state_q)
               S_FETCH: begin
                  if (rd_en) begin
                     if (addr_q == LAST_ADDR) begin
                        state_q <= S_DONE;
                     end else begin
                        addr_q <= addr_q + 1'b1;
                     end
                  end
               end
               S_DONE:  state_q <= S_DONE;
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.fb_rd_en   = rd_en;
   assign bus.fb_rd_addr = addr_q;
   assign bus.pix_r      = pix_rgb_q[11:8];
   assign bus.pix_g      = pix_rgb_q[7:4];
   assign bus.pix_b      = pix_rgb_q[3:0];
   assign bus.pix_valid  = pix_valid_q;
   assign bus.underflow  = underflow_q;

endmodule

// File: tb/tb_vga_pixel_prefetch.sv
// Bench for vga_pixel_prefetch on a reduced 16x6 frame: directed scenarios
// followed by random requests, frame starts and resets against a queue model.
module tb_vga_pixel_prefetch;

   localparam int H    = 16;
   localparam int V    = 6;
   localparam int D    = 16;
   localparam int RL   = 2;
   localparam int AW   = 10;
   localparam int LAST = H * V - 1;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   vga_pixel_prefetch_if #(.ADDR_W(AW)) vif ();

   vga_pixel_prefetch #(
      .H_VISIBLE_AREA (H),
      .V_VISIBLE_AREA (V),
      .FIFO_DEPTH     (D),
      .RD_LATENCY     (RL),
      .ADDR_W         (AW)
   ) dut (
      .vga_clk_i (clk),
      .reset_i   (rst),
      .bus       (vif)
   );

   typedef struct {
      int          due;
      logic [11:0] data;
   } infl_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;

   // framebuffer emulation: reads seen on the bus, by cycle
   bit          rd_log_en   [64];
   int          rd_log_addr [64];

   // reference model
   logic [11:0] m_fifo [$];
   infl_t       m_infl [$];
   int          m_addr  = 0;
   bit          m_fetch = 1'b0;
   bit          m_valid = 1'b0;
   logic [11:0] m_rgb   = 12'h000;
   bit          m_uf    = 1'b0;
   bit          exp_known = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_update(input bit r, input bit f, input bit q, input bit e_rd);
      if (r) begin
         m_fifo.delete();
         m_infl.delete();
         m_addr  = 0;
         m_fetch = 1'b0;
         m_valid = 1'b0;
         m_rgb   = 12'h000;
         m_uf    = 1'b0;
         return;
      end
      m_valid = 1'b0;
      m_rgb   = 12'h000;
      if (f) begin
         m_fifo.delete();
         m_infl.delete();
         m_addr  = 0;
         m_fetch = 1'b1;
         m_uf    = 1'b0;
         return;
      end
      if (q) begin
         if (m_fifo.size() > 0) begin
            m_rgb   = m_fifo.pop_front();
            m_valid = 1'b1;
         end else begin
            m_uf = 1'b1;
         end
      end
      if (m_infl.size() > 0 && m_infl[0].due == cyc) begin
         m_fifo.push_back(m_infl[0].data);
         void'(m_infl.pop_front());
      end
      if (e_rd) begin
         m_infl.push_back('{due: cyc + RL, data: 12'(m_addr)});
         if (m_addr == LAST) m_fetch = 1'b0;
         else                m_addr++;
      end
   endtask

   task automatic step(input bit r, input bit f, input bit q);
      bit e_rd;
      int src;
      @(negedge clk);
      if (exp_known) begin
         check_val("pix_valid", 32'(vif.pix_valid), 32'(m_valid));
         check_val("pix_rgb", 32'({vif.pix_r, vif.pix_g, vif.pix_b}), 32'(m_rgb));
         check_val("underflow", 32'(vif.underflow), 32'(m_uf));
      end
      rst             = r;
      vif.frame_start = f;
      vif.pix_req     = q;
      src = (cyc - RL) % 64;
      if (cyc >= RL && rd_log_en[src]) vif.fb_rd_data = 12'(rd_log_addr[src]);
      else                              vif.fb_rd_data = 12'($urandom);
      #1;
      e_rd = !r && !f && m_fetch && ((m_fifo.size() + m_infl.size()) < D);
      check_val("fb_rd_en", 32'(vif.fb_rd_en), 32'(e_rd));
      if (e_rd && vif.fb_rd_en) check_val("fb_rd_addr", 32'(vif.fb_rd_addr), 32'(m_addr));
      check_val("fifo_bound", 32'(int'(dut.count_q) <= D), 32'd1);
      rd_log_en[cyc % 64]   = vif.fb_rd_en;
      rd_log_addr[cyc % 64] = int'(vif.fb_rd_addr);
      model_update(r, f, q, e_rd);
      exp_known = 1'b1;
      cyc++;
   endtask

   initial begin
      rst             = 1'b1;
      vif.frame_start = 1'b0;
      vif.pix_req     = 1'b0;
      vif.fb_rd_data  = 12'h000;

      // reset, then idle without a frame start
      repeat (3)   step(1'b1, 1'b0, 1'b0);
      repeat (100) step(1'b0, 1'b0, 1'b0);

      // fill without popping, then stream a whole frame and run past its end
      step(1'b0, 1'b1, 1'b0);
      repeat (19) step(1'b0, 1'b0, 1'b0);
      check_val("fifo_full", 32'(dut.count_q), 32'(D));
      repeat (H * V + 8) step(1'b0, 1'b0, 1'b1);
      repeat (4) step(1'b0, 1'b0, 1'b0);

      // request right after frame start underflows; next frame start clears it
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);

      // restart with two reads in flight; request in the frame start cycle
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      repeat (8)  step(1'b0, 1'b0, 1'b0);
      repeat (30) step(1'b0, 1'b0, 1'b1);

      // reset mid-frame with requests active, then no reads until a frame start
      step(1'b1, 1'b0, 1'b1);
      repeat (20) step(1'b0, 1'b0, 1'b0);

      // random traffic
      step(1'b0, 1'b1, 1'b0);
      repeat (3000) begin
         step(($urandom % 1000) == 0, ($urandom % 250) == 0, ($urandom % 10) < 8);
      end
      step(1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
